// File: rtl/video_sprite_motion_ctrl.sv
// ----------------------------------------------------------------------------
// video_sprite_motion_ctrl
//
// Frame-synchronous motion controller for the sprite animation core. Every
// FRAME_DIV accepted frame_start pulses it moves a bouncing (x,y) sprite
// position one step inside the visible area. It then writes x_origin
// (byte address 0x4) and y_origin (byte address 0x8) to the sprite core over
// an Avalon-MM write-only master.
//
// Ports
//   clk              pixel clock
//   rst              synchronous reset, active-low
//   enable           1 = frame_start events are accepted while idle
//   frame_start      1-cycle pulse at the start of each frame
//   x_step, y_step   per-update step, in pixels and lines
//   avm_write        Avalon write strobe
//   avm_address      Avalon byte address (4 = x origin, 8 = y origin)
//   avm_writedata    origin value being written
//   avm_waitrequest  slave stall
//   busy             1 while a calc/write sequence is in progress
//   frame_miss       1-cycle pulse: frame_start arrived while busy
//
// Avalon handshake: a write is presented with avm_write=1 and a stable
// address and data. It completes on the first rising edge where
// avm_waitrequest=0. Until then, address, data and strobe are held unchanged.
// ----------------------------------------------------------------------------
module video_sprite_motion_ctrl #(
    parameter int H_DISPLAY    = 640,
    parameter int V_DISPLAY    = 480,
    parameter int SPRITE_HSIZE = 32,
    parameter int SPRITE_VSIZE = 32,
    parameter int X_INIT       = 0,
    parameter int Y_INIT       = 0,
    parameter int STEP_W       = 4,
    parameter int FRAME_DIV    = 1,
    parameter int AW           = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_start,
    input  logic [STEP_W-1:0] x_step,
    input  logic [STEP_W-1:0] y_step,
    output logic              avm_write,
    output logic [AW-1:0]     avm_address,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              frame_miss
);

    typedef enum logic [1:0] {IDLE, CALC, WR_X, WR_Y} state_t;

    localparam logic [31:0]   XM      = 32'(H_DISPLAY - SPRITE_HSIZE);
    localparam logic [31:0]   YM      = 32'(V_DISPLAY - SPRITE_VSIZE);
    localparam logic [31:0]   FD_LAST = 32'(FRAME_DIV - 1);
    localparam logic [AW-1:0] ADDR_X  = AW'(4);
    localparam logic [AW-1:0] ADDR_Y  = AW'(8);

    state_t      state_q, state_d;
    logic [31:0] x_pos_q, x_pos_d;
    logic [31:0] y_pos_q, y_pos_d;
    logic        x_neg_q, x_neg_d;     // 1 = moving toward 0
    logic        y_neg_q, y_neg_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic        frame_miss_q, frame_miss_d;
    logic [32:0] x_next, y_next;       // {new direction, new position}

    // One axis of the bounce. The position clamps at the edge, and the
    // direction flips only when the edge is reached with a non-zero step.
    // Because of this, a zero step never flips the direction.
    function automatic logic [32:0] axis_step(
        input logic [31:0]       pos,
        input logic [STEP_W-1:0] step,
        input logic              neg,
        input logic [31:0]       lim
    );
        logic [31:0] s;
        logic [31:0] np;
        logic        nd;
        s  = {{(32-STEP_W){1'b0}}, step};
        nd = neg;
        if (!neg) begin
            np = (pos + s > lim) ? lim : pos + s;
            if (np == lim && s != 32'd0) nd = 1'b1;
        end else begin
            np = (pos < s) ? 32'd0 : pos - s;
            if (np == 32'd0 && s != 32'd0) nd = 1'b0;
        end
        return {nd, np};
    endfunction

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            x_pos_q      <= 32'(X_INIT);
            y_pos_q      <= 32'(Y_INIT);
            x_neg_q      <= 1'b0;
            y_neg_q      <= 1'b0;
            frame_cnt_q  <= 32'd0;
            frame_miss_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_pos_q      <= x_pos_d;
            y_pos_q      <= y_pos_d;
            x_neg_q      <= x_neg_d;
            y_neg_q      <= y_neg_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_miss_q <= frame_miss_d;
        end
    end

    // Next state and datapath update
    always_comb begin
        state_d     = state_q;
        x_pos_d     = x_pos_q;
        y_pos_d     = y_pos_q;
        x_neg_d     = x_neg_q;
        y_neg_d     = y_neg_q;
        frame_cnt_d = frame_cnt_q;
        x_next      = axis_step(x_pos_q, x_step, x_neg_q, XM);
        y_next      = axis_step(y_pos_q, y_step, y_neg_q, YM);
        // A frame_start seen in any non-idle state is dropped and reported.
        frame_miss_d = frame_start && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (enable && frame_start) begin
                    if (frame_cnt_q == FD_LAST) begin
                        frame_cnt_d = 32'd0;
                        state_d     = CALC;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                    end
                end
            end
            CALC: begin
                x_pos_d = x_next[31:0];
                x_neg_d = x_next[32];
                y_pos_d = y_next[31:0];
                y_neg_d = y_next[32];
                state_d = WR_X;
            end
            WR_X: if (!avm_waitrequest) state_d = WR_Y;
            WR_Y: if (!avm_waitrequest) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from registered state only
    always_comb begin
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = 32'd0;
        unique case (state_q)
            WR_X: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_X;
                avm_writedata = x_pos_q;
            end
            WR_Y: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_Y;
                avm_writedata = y_pos_q;
            end
            default: ;
        endcase
        busy       = (state_q != IDLE);
        frame_miss = frame_miss_q;
    end

endmodule

// File: tb/tb_video_sprite_motion_ctrl.sv
module tb_video_sprite_motion_ctrl;
  localparam int XM = 608;
  localparam int YM = 448;
  localparam int XI = 606;
  localparam int YI = 446;
  localparam int FD = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [3:0]  x_step = 4'd0;
  logic [3:0]  y_step = 4'd0;
  logic        avm_waitrequest = 1'b0;
  logic        avm_write;
  logic [12:0] avm_address;
  logic [31:0] avm_writedata;
  logic        busy;
  logic        frame_miss;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  video_sprite_motion_ctrl #(
    .H_DISPLAY(640), .V_DISPLAY(480), .SPRITE_HSIZE(32), .SPRITE_VSIZE(32),
    .X_INIT(XI), .Y_INIT(YI), .STEP_W(4), .FRAME_DIV(FD), .AW(13)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .x_step(x_step), .y_step(y_step),
    .avm_write(avm_write), .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .frame_miss(frame_miss)
  );

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];       // expected write data
  logic [12:0] exp_addr_q[$];  // expected write address
  int          exp_cyc_q[$];   // cycle in which the write must complete
  int          miss_q[$];      // cycles in which frame_miss must be 1
  int          busy_from = -1;
  int          busy_to = -2;
  bit          mon_on = 1'b0;

  // reference model: position, direction (+1/-1), enabled frame count
  int mx, my, mdx, mdy, mframes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mx = XI; my = YI; mdx = 1; mdy = 1; mframes = 0;
  endtask

  // Bounce: move by step in the current direction and stop at the edge,
  // reversing direction there. A zero step leaves everything alone.
  task automatic move(inout int p, inout int d, input int s, input int lim);
    if (s == 0) return;
    p = p + d * s;
    if (p >= lim) begin p = lim; d = -1; end
    else if (p <= 0) begin p = 0; d = 1; end
  endtask

  // ---------------- driver ----------------
  // One frame_start pulse. If it triggers an update, the driver also plays
  // the write sequence with sx/sy stall cycles. If miss=1, it adds a second
  // frame_start during the x write.
  task automatic issue(input bit en, input int xs, input int ys,
                       input int sx, input int sy, input bit miss);
    int n;
    bit acc;
    enable = en; frame_start = 1'b1;
    x_step = 4'(xs); y_step = 4'(ys);
    n = cyc;
    acc = 1'b0;
    if (en) begin
      mframes++;
      if (mframes % FD == 0) acc = 1'b1;
    end
    if (acc) begin
      move(mx, mdx, xs, XM);
      move(my, mdy, ys, YM);
      exp_q.push_back(32'(mx)); exp_addr_q.push_back(13'd4); exp_cyc_q.push_back(n + 2 + sx);
      exp_q.push_back(32'(my)); exp_addr_q.push_back(13'd8); exp_cyc_q.push_back(n + 3 + sx + sy);
      busy_from = n + 1;
      busy_to = n + 3 + sx + sy;
      if (miss) miss_q.push_back(n + 3);
    end
    step();
    frame_start = 1'b0;
    if (acc) begin
      for (int c = n + 2; c <= n + 3 + sx + sy; c++) begin
        step();
        avm_waitrequest = (c < n + 2 + sx) || (c >= n + 3 + sx && c < n + 3 + sx + sy);
        frame_start = miss && (c == n + 2);
      end
      step();
      avm_waitrequest = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_on && rst) begin
      bit exp_b;
      bit exp_m;
      exp_b = (cyc >= busy_from) && (cyc <= busy_to);
      check("busy", 32'(busy), 32'(exp_b));
      exp_m = (miss_q.size() > 0) && (miss_q[0] == cyc);
      if (exp_m) void'(miss_q.pop_front());
      check("frame_miss", 32'(frame_miss), 32'(exp_m));
      if (avm_write) begin
        if (exp_q.size() == 0) begin
          check("spurious_write", 32'(avm_write), 32'd0);
        end else begin
          check("write_addr", 32'(avm_address), 32'(exp_addr_q[0]));
          check("write_data", avm_writedata, exp_q[0]);
          if (!avm_waitrequest) begin
            check("write_cycle", 32'(cyc), 32'(exp_cyc_q[0]));
            void'(exp_q.pop_front());
            void'(exp_addr_q.pop_front());
            void'(exp_cyc_q.pop_front());
          end
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        check("write_present", 32'(avm_write), 32'd1);
        void'(exp_q.pop_front());
        void'(exp_addr_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    model_reset();
    rst = 1'b0;
    repeat (3) step();
    check("rst_write", 32'(avm_write), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_data", avm_writedata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miss", 32'(frame_miss), 32'd0);
    rst = 1'b1;
    mon_on = 1'b1;
    step();

    // frame_start ignored while disabled
    repeat (3) issue(1'b0, 3, 2, 0, 0, 1'b0);
    repeat (3) step();

    // bounce off the right/bottom edges: 606+4 -> 608, then 604
    repeat (3) issue(1'b1, 4, 2, 0, 0, 1'b0);
    repeat (3) issue(1'b1, 4, 2, 0, 0, 1'b0);
    // zero step: no move and no flip
    repeat (3) issue(1'b1, 0, 0, 0, 0, 1'b0);
    // 5-cycle stall on the x write, plus a frame_start during WR_X
    repeat (2) issue(1'b1, 1, 1, 0, 0, 1'b0);
    issue(1'b1, 7, 9, 5, 0, 1'b1);
    issue(1'b1, 2, 2, 0, 3, 1'b0);

    // randomized traffic
    repeat (400) begin
      issue(($urandom_range(0, 4) != 0), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (3) step();

    // reset applied during the y write
    while (mframes % FD != FD - 1) issue(1'b1, 1, 1, 0, 0, 1'b0);
    repeat (2) step();
    mon_on = 1'b0;
    enable = 1'b1; frame_start = 1'b1; x_step = 4'd5; y_step = 4'd5;
    mframes++;
    move(mx, mdx, 5, XM);
    move(my, mdy, 5, YM);
    n = cyc;
    step();
    frame_start = 1'b0;
    step();
    check("rw_x_write", 32'(avm_write), 32'd1);
    check("rw_x_addr", 32'(avm_address), 32'd4);
    check("rw_x_data", avm_writedata, 32'(mx));
    step();
    check("rw_y_addr", 32'(avm_address), 32'd8);
    check("rw_y_data", avm_writedata, 32'(my));
    check("rw_y_cycle", 32'(cyc), 32'(n + 3));
    avm_waitrequest = 1'b1;
    rst = 1'b0;
    step();
    check("rst_wy_write", 32'(avm_write), 32'd0);
    check("rst_wy_busy", 32'(busy), 32'd0);
    check("rst_wy_addr", 32'(avm_address), 32'd0);
    check("rst_wy_data", avm_writedata, 32'd0);
    avm_waitrequest = 1'b0;
    rst = 1'b1;
    model_reset();
    exp_q.delete(); exp_addr_q.delete(); exp_cyc_q.delete(); miss_q.delete();
    busy_from = -1; busy_to = -2;
    step();
    mon_on = 1'b1;
    // positions restart from the initial values
    repeat (3) issue(1'b1, 1, 1, 0, 0, 1'b0);
    repeat (3) issue(1'b1, 2, 3, 1, 1, 1'b0);
    repeat (5) step();
    mon_on = 1'b0;

    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("misses_drained", 32'(miss_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
